// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_pkg
// Purpose : Shared types, constants and helpers for the programmable divider.
// Revision: 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  localparam int DIV_W_DEF = 8;

  typedef logic [DIV_W_DEF-1:0] div_t;

  localparam div_t DIV_STOP = div_t'(0);
  localparam div_t DIV_MIN  = div_t'(2);

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of high cycles in a period of length d: ceil(d/2).
  function automatic int unsigned hi_cycles(input int unsigned d);
    return (d + 1) >> 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_chan
// Purpose : One divider channel: counter, active/pending divisor, clk_out/rise.
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic             align,
  output logic             clk_out,
  output logic             clk_rise,
  output logic             pending
);

  localparam logic [DIV_W-1:0] c_rst_div = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] c_rst_cnt = (RESET_DIV == 0) ? '0 : DIV_W'(RESET_DIV - 1);
  localparam logic [DIV_W-1:0] c_stop    = DIV_W'(DIV_STOP);
  localparam logic [DIV_W-1:0] c_one     = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_cur;
  logic [DIV_W-1:0] r_div_pend;
  logic             r_pending;
  logic             r_clk_out;
  logic             r_clk_rise;

  logic             w_boundary;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             w_out_nxt;
  logic             w_pending_nxt;

  always_comb begin
    // A stopped channel treats every cycle as a boundary so updates land at once.
    w_boundary = (r_div_cur == c_stop) || (r_cnt == (r_div_cur - c_one)) || align;
    w_div_nxt  = (w_boundary && r_pending) ? r_div_pend : r_div_cur;
    w_cnt_nxt  = r_cnt + c_one;
    w_out_nxt  = (w_cnt_nxt < DIV_W'(hi_cycles(32'(r_div_cur))));
    if (w_boundary) begin
      w_cnt_nxt = '0;
      w_out_nxt = (w_div_nxt != c_stop);
    end
    // A load in a boundary cycle re-arms pending; the boundary only clears the old flag.
    w_pending_nxt = (r_pending && !w_boundary) || load;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_div_cur  <= c_rst_div;
      r_cnt      <= c_rst_cnt;
      r_div_pend <= '0;
      r_pending  <= 1'b0;
      r_clk_out  <= 1'b0;
      r_clk_rise <= 1'b0;
    end else begin
      r_div_cur  <= w_div_nxt;
      r_cnt      <= w_cnt_nxt;
      r_clk_out  <= w_out_nxt;
      r_clk_rise <= w_out_nxt && !r_clk_out;
      r_pending  <= w_pending_nxt;
      if (load) begin
        r_div_pend <= load_div;
      end
    end
  end

  assign clk_out  = r_clk_out;
  assign clk_rise = r_clk_rise;
  assign pending  = r_pending;

endmodule
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_prog
// Purpose : Runtime-programmable multi-channel clock divider with cfg handshake.
//           Optional CLKDIV_ALIGN_EN adds an align input forcing a common boundary.
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int DIV_W     = 8,
  parameter  int RESET_DIV = 2,
  localparam int CH_W      = ch_width(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              reset,
`ifdef CLKDIV_ALIGN_EN
  input  logic              align,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] clk_rise,
  output logic [NUM_CH-1:0] pending
);

  logic              w_align;
  logic              w_in_range;
  logic              w_accept;
  logic              w_div_one;
  logic [DIV_W-1:0]  w_div_clamped;
  logic [NUM_CH-1:0] w_load;
  logic              r_cfg_err;

`ifdef CLKDIV_ALIGN_EN
  assign w_align = align;
`else
  assign w_align = 1'b0;
`endif

  // Out-of-range channels look ready so the requester is never stalled on them.
  assign w_in_range    = (32'(cfg_ch) < NUM_CH);
  assign cfg_ready     = w_in_range ? ~pending[cfg_ch] : 1'b1;
  assign w_accept      = cfg_valid && cfg_ready;
  assign w_div_one     = (cfg_div == DIV_W'(1));
  assign w_div_clamped = w_div_one ? DIV_W'(DIV_MIN) : cfg_div;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_accept && (!w_in_range || w_div_one);
    end
  end

  assign cfg_err = r_cfg_err;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_load[i] = w_accept && w_in_range && (32'(cfg_ch) == 32'(i));

      clk_div_chan #(
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
      ) u_chan (
        .clk_in   (clk_in),
        .reset    (reset),
        .load     (w_load[i]),
        .load_div (w_div_clamped),
        .align    (w_align),
        .clk_out  (clk_out[i]),
        .clk_rise (clk_rise[i]),
        .pending  (pending[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_div_prog
// Purpose : Directed self-checking bench for clk_div_prog (3 channels, D=2 reset).
// Revision: 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] clk_rise;
  logic [NUM_CH-1:0] pending;
`ifdef CLKDIV_ALIGN_EN
  logic              align;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  clk_div_prog #(
    .NUM_CH    (NUM_CH),
    .DIV_W     (DIV_W),
    .RESET_DIV (2)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
`ifdef CLKDIV_ALIGN_EN
    .align     (align),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .clk_rise  (clk_rise),
    .pending   (pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cfg_set(input logic [1:0] ch, input logic [DIV_W-1:0] div);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = div;
  endtask

  // Runs n edges, dropping cfg_valid after the first; bit k of each pattern is the
  // expected value after the (k+1)th edge.
  task automatic watch(input int ch, input int n, input logic [15:0] out_pat,
                       input logic [15:0] pend_pat, input logic [15:0] rise_pat,
                       input logic [15:0] err_pat, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      cfg_valid = 1'b0;
      check($sformatf("%s_out%0d", tag, k),  32'(clk_out[ch]),  32'(out_pat[k]));
      check($sformatf("%s_pend%0d", tag, k), 32'(pending[ch]),  32'(pend_pat[k]));
      check($sformatf("%s_rise%0d", tag, k), 32'(clk_rise[ch]), 32'(rise_pat[k]));
      check($sformatf("%s_err%0d", tag, k),  32'(cfg_err),      32'(err_pat[k]));
    end
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
`ifdef CLKDIV_ALIGN_EN
    align     = 1'b0;
`endif
    tick();
    tick();
    check("rst_out",  32'(clk_out),  32'h0);
    check("rst_rise", 32'(clk_rise), 32'h0);
    check("rst_pend", 32'(pending),  32'h0);
    check("rst_err",  32'(cfg_err),  32'h0);
    reset = 1'b0;

    // Reset divisor 2: high on odd edges after release, rise every other edge.
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("d2_out%0d", k),  32'(clk_out),  (k % 2 == 1) ? 32'h7 : 32'h0);
      check($sformatf("d2_rise%0d", k), 32'(clk_rise), (k % 2 == 1) ? 32'h7 : 32'h0);
    end

    // ch0 -> 5 while running at 2: old period finishes, then 3 high / 2 low.
    cfg_set(2'd0, 8'd5);
    check("ch0_ready", 32'(cfg_ready), 32'h1);
    watch(0, 10, 16'b11_1001_1101, 16'b00_0000_0011, 16'b00_1000_0101, 16'h0, "ch0d5");

    // ch1 -> 0: finishes its period then holds low.
    cfg_set(2'd1, 8'd0);
    watch(1, 6, 16'b00_0001, 16'b00_0011, 16'b00_0001, 16'h0, "ch1stop");
    // ch1 -> 7 while stopped: applies next edge, then 4 high / 3 low.
    cfg_set(2'd1, 8'd7);
    check("ch1_ready", 32'(cfg_ready), 32'h1);
    watch(1, 10, 16'b11_0001_1110, 16'b00_0000_0001, 16'b01_0000_0010, 16'h0, "ch1d7");

    // Back-to-back requests to ch2: second stalls until the first is applied.
    cfg_set(2'd2, 8'd3);
    check("ch2_ready0", 32'(cfg_ready), 32'h1);
    tick();
    cfg_div = 8'd4;
    check("ch2_ready1", 32'(cfg_ready),  32'h0);
    check("ch2_pend1",  32'(pending[2]), 32'h1);
    check("ch2_out1",   32'(clk_out[2]), 32'h1);
    tick();
    check("ch2_ready2", 32'(cfg_ready),  32'h0);
    check("ch2_out2",   32'(clk_out[2]), 32'h0);
    tick();
    check("ch2_ready3", 32'(cfg_ready),  32'h1);
    check("ch2_pend3",  32'(pending[2]), 32'h0);
    check("ch2_out3",   32'(clk_out[2]), 32'h1);
    watch(2, 7, 16'b100_1101, 16'b000_0011, 16'b100_0100, 16'h0, "ch2d4");

    // cfg_div=1 clamps to 2 with an error pulse.
    cfg_set(2'd2, 8'd1);
    check("clamp_ready", 32'(cfg_ready), 32'h1);
    watch(2, 6, 16'b10_1001, 16'b00_0111, 16'b10_1000, 16'b00_0001, "clamp");

    // Out-of-range channel: ready, dropped, error pulse, no pending anywhere.
    cfg_set(2'd3, 8'd9);
    check("oor_ready", 32'(cfg_ready), 32'h1);
    tick();
    cfg_valid = 1'b0;
    check("oor_err1",  32'(cfg_err), 32'h1);
    check("oor_pend1", 32'(pending), 32'h0);
    tick();
    check("oor_err2",  32'(cfg_err), 32'h0);
    check("oor_pend2", 32'(pending), 32'h0);

    // Async reset mid-high on ch0 with a pending update: output drops immediately.
    cfg_set(2'd0, 8'd9);
    tick();
    cfg_valid = 1'b0;
    check("pre_rst_out0",  32'(clk_out[0]), 32'h1);
    check("pre_rst_pend0", 32'(pending[0]), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out",  32'(clk_out),  32'h0);
    check("arst_pend", 32'(pending),  32'h0);
    check("arst_rise", 32'(clk_rise), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    watch(0, 4, 16'b0101, 16'b0000, 16'b0101, 16'h0, "restart");

`ifdef CLKDIV_ALIGN_EN
    // Channels at 3/4/6, aligned: common boundary now and again every 12 edges.
    cfg_set(2'd0, 8'd3);
    tick();
    cfg_set(2'd1, 8'd4);
    tick();
    cfg_set(2'd2, 8'd6);
    tick();
    cfg_valid = 1'b0;
    repeat (4) tick();
    check("al_pend", 32'(pending), 32'h0);
    align = 1'b1;
    tick();
    align = 1'b0;
    check("al_out0", 32'(clk_out), 32'h7);
    repeat (2) tick();
    check("al_out2", 32'(clk_out), 32'h4);
    repeat (10) tick();
    check("al_out12",  32'(clk_out),  32'h7);
    check("al_rise12", 32'(clk_rise), 32'h7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
